// File: rtl/stack_regfile.sv
// Register file for the 16-bit stack machine: one general port with a registered,
// write-through read; a dedicated RA port; and an SP register with guarded push/pop.
module stack_regfile #(
    parameter int               WIDTH    = 16,
    parameter int               NUM_REGS = 16,
    parameter int               ADDR_W   = 4,
    parameter int               RA_IDX   = 0,
    parameter int               SP_IDX   = 3,
    parameter logic [WIDTH-1:0] SP_RESET = 16'h7FFE,
    parameter logic [WIDTH-1:0] SP_MIN   = 16'h4000,
    parameter int               STEP     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  din,
    input  logic              we,
    output logic [WIDTH-1:0]  dout,
    input  logic [WIDTH-1:0]  ra_din,
    input  logic              ra_we,
    output logic [WIDTH-1:0]  ra_dout,
    input  logic              sp_push,
    input  logic              sp_pop,
    output logic [WIDTH-1:0]  sp_dout,
    output logic              sp_ovf,
    output logic              sp_unf
);

    localparam logic [WIDTH:0] STEP_EXT  = (WIDTH+1)'(STEP);
    // Push is legal while SP - STEP >= SP_MIN; written as an add so nothing can underflow.
    localparam logic [WIDTH:0] PUSH_MIN  = {1'b0, SP_MIN} + STEP_EXT;
    localparam logic [WIDTH:0] RESET_EXT = {1'b0, SP_RESET};

    logic [WIDTH-1:0] regs     [NUM_REGS];
    logic [WIDTH-1:0] regs_nxt [NUM_REGS];
    logic [WIDTH-1:0] rd_nxt;
    logic [WIDTH:0]   sp_ext;
    logic             sp_written;
    logic             ovf_set;
    logic             unf_set;

    assign sp_ext     = {1'b0, regs[SP_IDX]};
    assign sp_written = we && (addr == ADDR_W'(SP_IDX));

    // NOTE: every variable driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        ovf_set = 1'b0;
        unf_set = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_nxt[i] = regs[i];
            if (we && (addr == ADDR_W'(i)))
                regs_nxt[i] = din;
        end

        if (ra_we)
            regs_nxt[RA_IDX] = ra_din;

        if (!sp_written) begin
            if (sp_push && !sp_pop) begin
                if (sp_ext >= PUSH_MIN)
                    regs_nxt[SP_IDX] = regs[SP_IDX] - WIDTH'(STEP);
                else
                    ovf_set = 1'b1;
            end else if (sp_pop && !sp_push) begin
                if (sp_ext + STEP_EXT <= RESET_EXT)
                    regs_nxt[SP_IDX] = regs[SP_IDX] + WIDTH'(STEP);
                else
                    unf_set = 1'b1;
            end
        end

        // Read the post-update value so a same-cycle write is visible next cycle.
        rd_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i))
                rd_nxt = regs_nxt[i];
        end
    end

    // NOTE: this is a small flop array, not a RAM macro, so every entry is reset explicitly; state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            dout   <= '0;
            sp_ovf <= 1'b0;
            sp_unf <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= regs_nxt[i];
            dout   <= rd_nxt;
            sp_ovf <= sp_ovf | ovf_set;
            sp_unf <= sp_unf | unf_set;
        end
    end

    assign ra_dout = regs[RA_IDX];
    assign sp_dout = regs[SP_IDX];

endmodule

// File: tb/tb_stack_regfile.sv
// Self-checking bench for stack_regfile (NUM_REGS=10) against a behavioural model
// of the register file kept as a plain array with integer SP arithmetic.
module tb_stack_regfile;

    localparam int          NR     = 10;
    localparam int          RA     = 0;
    localparam int          SP     = 3;
    localparam int          SP_TOP = 'h7FFE;
    localparam int          SP_BOT = 'h4000;
    localparam int          STP    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  addr = '0;
    logic [15:0] din = '0;
    logic        we = 1'b0;
    logic [15:0] dout;
    logic [15:0] ra_din = '0;
    logic        ra_we = 1'b0;
    logic [15:0] ra_dout;
    logic        sp_push = 1'b0;
    logic        sp_pop = 1'b0;
    logic [15:0] sp_dout;
    logic        sp_ovf;
    logic        sp_unf;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_regs [NR];
    int m_dout;
    bit m_ovf;
    bit m_unf;

    stack_regfile #(
        .WIDTH(16), .NUM_REGS(NR), .ADDR_W(4), .RA_IDX(RA), .SP_IDX(SP),
        .SP_RESET(16'h7FFE), .SP_MIN(16'h4000), .STEP(STP)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .dout(dout),
        .ra_din(ra_din), .ra_we(ra_we), .ra_dout(ra_dout),
        .sp_push(sp_push), .sp_pop(sp_pop), .sp_dout(sp_dout),
        .sp_ovf(sp_ovf), .sp_unf(sp_unf)
    );

    always #5 clk = ~clk;

    // Applies the register-file rules to the model for the inputs present at this edge.
    task automatic model_edge();
        int nxt [NR];
        if (reset) begin
            foreach (m_regs[i]) m_regs[i] = (i == SP) ? SP_TOP : 0;
            m_dout = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        foreach (m_regs[i]) nxt[i] = m_regs[i];
        if (we && addr < NR) nxt[addr] = din;
        if (ra_we) nxt[RA] = ra_din;
        if (!(we && addr == SP)) begin
            if (sp_push && !sp_pop) begin
                if (m_regs[SP] - STP >= SP_BOT) nxt[SP] = m_regs[SP] - STP;
                else m_ovf = 1;
            end else if (sp_pop && !sp_push) begin
                if (m_regs[SP] + STP <= SP_TOP) nxt[SP] = m_regs[SP] + STP;
                else m_unf = 1;
            end
        end
        m_dout = (addr < NR) ? nxt[addr] : 0;
        foreach (m_regs[i]) m_regs[i] = nxt[i];
    endtask

    // One clock: edge, model update, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; we = 0; ra_we = 0; sp_push = 0; sp_pop = 0;
        addr = '0; din = '0; ra_din = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; we = 1; addr = 4'd3; din = 16'h1111; sp_push = 1;
        tick();
        idle_inputs();
        tests++; if (ra_dout !== 16'h0000) begin fails++; $display("FAIL reset_ra: got %h want 0000", ra_dout); end
        tests++; if (sp_dout !== 16'h7FFE) begin fails++; $display("FAIL reset_sp: got %h want 7ffe", sp_dout); end
        tests++; if (dout !== 16'h0000) begin fails++; $display("FAIL reset_dout: got %h want 0000", dout); end
        tests++; if (sp_ovf !== 1'b0 || sp_unf !== 1'b0) begin fails++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", sp_ovf, sp_unf); end
    endtask

    task automatic test_decode();
        idle_inputs(); we = 1; addr = 4'd5; din = 16'hBEEF;
        tick();
        idle_inputs(); addr = 4'd5;
        tick();
        tests++; if (dout !== 16'hBEEF) begin fails++; $display("FAIL decode_read5: got %h want beef", dout); end
        addr = 4'd6;
        tick();
        tests++; if (dout !== 16'h0000) begin fails++; $display("FAIL decode_read6: got %h want 0000", dout); end
    endtask

    task automatic test_bypass();
        idle_inputs(); we = 1; addr = 4'd2; din = 16'h1234;
        tick();
        tests++; if (dout !== 16'h1234) begin fails++; $display("FAIL bypass_write_read: got %h want 1234", dout); end
    endtask

    task automatic test_ra_priority();
        idle_inputs(); ra_we = 1; ra_din = 16'hAAAA; we = 1; addr = 4'd0; din = 16'h5555;
        tick();
        idle_inputs();
        tests++; if (ra_dout !== 16'hAAAA) begin fails++; $display("FAIL ra_priority: got %h want aaaa", ra_dout); end
        tests++; if (dout !== 16'hAAAA) begin fails++; $display("FAIL ra_bypass_dout: got %h want aaaa", dout); end
    endtask

    task automatic test_sp_bounds();
        idle_inputs(); reset = 1; tick();
        idle_inputs(); sp_push = 1; tick();
        tests++; if (sp_dout !== 16'h7FFC) begin fails++; $display("FAIL sp_push: got %h want 7ffc", sp_dout); end
        idle_inputs(); sp_pop = 1; tick();
        tests++; if (sp_dout !== 16'h7FFE || sp_unf !== 1'b0) begin fails++; $display("FAIL sp_pop: got %h unf=%b want 7ffe unf=0", sp_dout, sp_unf); end
        tick();
        tests++; if (sp_dout !== 16'h7FFE || sp_unf !== 1'b1) begin fails++; $display("FAIL sp_underflow: got %h unf=%b want 7ffe unf=1", sp_dout, sp_unf); end
        idle_inputs(); we = 1; addr = 4'd3; din = 16'h4000; sp_pop = 1; tick();
        tests++; if (sp_dout !== 16'h4000) begin fails++; $display("FAIL sp_write_wins: got %h want 4000", sp_dout); end
        idle_inputs(); sp_push = 1; tick();
        tests++; if (sp_dout !== 16'h4000 || sp_ovf !== 1'b1) begin fails++; $display("FAIL sp_overflow: got %h ovf=%b want 4000 ovf=1", sp_dout, sp_ovf); end
        idle_inputs(); sp_push = 1; sp_pop = 1; tick();
        tests++; if (sp_dout !== 16'h4000 || sp_ovf !== 1'b1 || sp_unf !== 1'b1) begin fails++; $display("FAIL sp_push_pop: got %h ovf=%b unf=%b want 4000 1 1", sp_dout, sp_ovf, sp_unf); end
    endtask

    task automatic test_reset_mid();
        idle_inputs(); reset = 1; tick();
        idle_inputs();
        tests++; if (sp_dout !== 16'h7FFE || ra_dout !== 16'h0000 || dout !== 16'h0000) begin fails++; $display("FAIL midreset_regs: sp=%h ra=%h dout=%h want 7ffe 0000 0000", sp_dout, ra_dout, dout); end
        tests++; if (sp_ovf !== 1'b0 || sp_unf !== 1'b0) begin fails++; $display("FAIL midreset_flags: ovf=%b unf=%b want 0 0", sp_ovf, sp_unf); end
        addr = 4'd5; tick();
        tests++; if (dout !== 16'h0000) begin fails++; $display("FAIL midreset_reg5: got %h want 0000", dout); end
    endtask

    task automatic test_out_of_range();
        idle_inputs(); we = 1; addr = 4'd15; din = 16'hFFFF; tick();
        tests++; if (dout !== 16'h0000) begin fails++; $display("FAIL oob_write_read: got %h want 0000", dout); end
        idle_inputs();
        for (int a = 0; a < NR; a++) begin
            addr = 4'(a); tick();
            tests++; if (dout !== 16'(m_regs[a])) begin fails++; $display("FAIL oob_scan r%0d: got %h want %h", a, dout, 16'(m_regs[a])); end
        end
        addr = 4'd15; tick();
        tests++; if (dout !== 16'h0000) begin fails++; $display("FAIL oob_read15: got %h want 0000", dout); end
    endtask

    task automatic test_random();
        int pick;
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            reset   = ($urandom_range(0, 99) < 2);
            addr    = 4'($urandom_range(0, 15));
            we      = ($urandom_range(0, 99) < 30);
            ra_we   = ($urandom_range(0, 99) < 15);
            ra_din  = 16'($urandom);
            sp_push = ($urandom_range(0, 99) < 40);
            sp_pop  = ($urandom_range(0, 99) < 40);
            pick    = $urandom_range(0, 4);
            case (pick)
                0: din = 16'h4000;
                1: din = 16'h4002;
                2: din = 16'h7FFE;
                3: din = 16'h7FFC;
                default: din = 16'($urandom);
            endcase
            tick();
            tests++;
            if (dout !== 16'(m_dout) || ra_dout !== 16'(m_regs[RA]) || sp_dout !== 16'(m_regs[SP]) ||
                sp_ovf !== m_ovf || sp_unf !== m_unf) begin
                fails++;
                $display("FAIL random[%0d]: dout=%h ra=%h sp=%h ovf=%b unf=%b want %h %h %h %b %b",
                         n, dout, ra_dout, sp_dout, sp_ovf, sp_unf,
                         16'(m_dout), 16'(m_regs[RA]), 16'(m_regs[SP]), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 0;
        m_dout = 0; m_ovf = 0; m_unf = 0;
        test_reset();
        test_decode();
        test_bypass();
        test_ra_priority();
        test_sp_bounds();
        test_reset_mid();
        test_out_of_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stack_regfile.md
Name: stack_regfile

Overview:
Parametrised register file for the 16-bit stack machine. It provides one general read/write port with a registered read, a dedicated return-address (RA) port, and a stack-pointer (SP) register with hardware push/pop stepping and sticky overflow/underflow flags. Per-register write decode ensures that a write lands only in the addressed register. It sits between the control unit and the datapath muxes.

Parameters:
WIDTH, 16, data width of every register
NUM_REGS, 16, number of implemented registers; must be ≤ 2**ADDR_W
ADDR_W, 4, address width
RA_IDX, 0, index of the return-address register
SP_IDX, 3, index of the stack-pointer register
SP_RESET, 16'h7FFE, SP value after reset
SP_MIN, 16'h4000, lowest legal SP value; stack grows down
STEP, 2, SP byte step per push/pop

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
addr  in  ADDR_W  general port register index for read and write
din  in  WIDTH  general port write data
we  in  1  general port write enable
dout  out  WIDTH  registered read data for addr
ra_din  in  WIDTH  RA port write data
ra_we  in  1  RA port write enable
ra_dout  out  WIDTH  current RA contents, combinational from the register
sp_push  in  1  decrement SP by STEP
sp_pop  in  1  increment SP by STEP
sp_dout  out  WIDTH  current SP contents, combinational from the register
sp_ovf  out  1  sticky flag: a push was refused
sp_unf  out  1  sticky flag: a pop was refused

Behaviour:
- Reset (sampled at a clk edge while reset=1):
  - All registers clear to 0, except SP, which loads SP_RESET.
  - dout, sp_ovf and sp_unf clear to 0.
  - Reset overrides every other input in that cycle.
- Write decode:
  - At each edge, register i takes `din` only when we=1 and addr==i.
  - A write to addr ≥ NUM_REGS is dropped with no side effect.
- RA register:
  - ra_we=1 loads ra_din.
  - If ra_we=1 and we=1 with addr==RA_IDX in the same cycle, ra_din wins.
- SP register, next-state priority from highest to lowest:
  - 1. A general write (we=1, addr==SP_IDX) loads din. Any push/pop in that cycle is ignored, and no flag is set.
  - 2. sp_push and sp_pop both asserted: SP unchanged, no flag change.
  - 3. sp_push alone: if SP − STEP ≥ SP_MIN, SP ← SP − STEP. Otherwise SP is unchanged and sp_ovf ← 1.
  - 4. sp_pop alone: if SP + STEP ≤ SP_RESET, SP ← SP + STEP. Otherwise SP is unchanged and sp_unf ← 1.
  - All comparisons are unsigned on WIDTH+1 bits, so there is no wrap-around.
- Flags: sp_ovf and sp_unf are sticky and clear only on reset.
- Read port:
  - dout ← next-state value of register[addr] at each edge, giving one-cycle latency.
  - A same-cycle write to the read address (via we, ra_we or push/pop) is therefore visible in dout on the next cycle. This is write-through bypass.
  - addr ≥ NUM_REGS reads 0.
- ra_dout and sp_dout reflect current register state with no bypass.

Test Plan:
- Reset → ra_dout=0, sp_dout=16'h7FFE, dout=0, sp_ovf=0, sp_unf=0.
- Write addr=5, din=16'hBEEF, then read addr=5, and read addr=6 → dout=16'hBEEF one cycle after the addr=5 read is presented; register 6 still reads 0, proving per-register decode.
- Same cycle: we=1, addr=2, din=16'h1234 → next-cycle dout=16'h1234 (bypass).
- Same cycle: ra_we=1, ra_din=16'hAAAA, we=1, addr=0, din=16'h5555 → ra_dout=16'hAAAA.
- SP boundaries:
  - Push from reset → sp_dout=16'h7FFC.
  - A pop followed by a further pop → sp_dout=16'h7FFE and sp_unf=1.
  - Write SP=16'h4000, then push → sp_dout stays 16'h4000 and sp_ovf=1.
  - sp_push and sp_pop together → no change.
- Assert reset mid-sequence with flags set and SP=16'h4000 → all reset values restored on the next edge; flags cleared; write to addr=15 with NUM_REGS=10 → no register changes, and a read of addr=15 returns 0.
